// File: rtl/stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stage_ctrl
//  Purpose  : Multi-cycle pipeline-stage sequencer for a single-issue RV64
//             core. Walks each instruction through FETCH -> WAIT -> DECODE ->
//             EXEC -> WB, owns the program counter and the latched
//             instruction word, gates register-file writes to the WB cycle,
//             and parks in HALT on EBREAK until reset.
//  Ports    :
//    clk, rst_n            clock, asynchronous active-low reset
//    imem_req_o/addr_o     one-cycle fetch strobe and address (= PC)
//    imem_valid_i/rdata_i  fetch response, only honoured in WAIT
//    inst_o, pc_o          latched instruction word and PC to the decoder
//    alu_busy_i            multi-cycle MUL/DIV in progress (stalls EXEC)
//    exit_i                EBREAK seen by the decoder
//    rf_wen_i, rf_we_o     register-write request and its WB-gated strobe
//    next_pc_valid_i/_i    redirect target, else PC+4
//    state_o, halted_o     state encoding and HALT flag
//    cycle_cnt_o/instret_o performance counters
//  Config   : define PERF_CNT_EN to build the performance counters; without
//             it both counter ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module stage_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  // decoder interface
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  input  logic        alu_busy_i,
  input  logic        exit_i,
  input  logic        rf_wen_i,
  output logic        rf_we_o,
  input  logic        next_pc_valid_i,
  input  logic [63:0] next_pc_i,
  // status
  output logic [2:0]  state_o,
  output logic        halted_o,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instret_o
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_WAIT   = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Redirect targets are forced to word alignment, so the low two bits of
  // next_pc_i never reach the PC.
  logic [1:0]  unused_next_pc_lsb;
  assign unused_next_pc_lsb = next_pc_i[1:0];

  // --------------------------------------------------------------------------
  // State, PC and instruction registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;

    case (state_q)
      S_FETCH: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // The response is only accepted here; a response arriving in any
        // other state (including one left over from before a reset) is dropped.
        if (imem_valid_i) begin
          inst_d  = imem_rdata_i;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        if (!alu_busy_i) begin
          state_d = exit_i ? S_HALT : S_WB;
        end
      end

      S_WB: begin
        // PC+4 wraps naturally in 64-bit arithmetic.
        pc_d    = next_pc_valid_i ? {next_pc_i[63:2], 2'b00} : (pc_q + 64'd4);
        state_d = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      // Unused encodings 6 and 7 recover to FETCH.
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs decoded from the current state
  // --------------------------------------------------------------------------
  assign imem_req_o  = (state_q == S_FETCH);
  assign imem_addr_o = pc_q;
  assign inst_o      = inst_q;
  assign pc_o        = pc_q;
  assign rf_we_o     = (state_q == S_WB) && rf_wen_i;
  assign halted_o    = (state_q == S_HALT);
  assign state_o     = state_q;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt_q;
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 64'd0;
      instret_q   <= 64'd0;
    end else begin
      if (state_q != S_HALT) begin
        cycle_cnt_q <= cycle_cnt_q + 64'd1;
      end
      if (state_q == S_WB) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`else
  assign cycle_cnt_o = 64'd0;
  assign instret_o   = 64'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_ctrl
//  Purpose  : Directed self-checking bench for stage_ctrl. Each scenario task
//             drives the handshake inputs on the falling edge and checks the
//             DUT outputs there against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1  = 32'h0010_0093;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        alu_busy_i;
  logic        exit_i;
  logic        rf_wen_i;
  logic        rf_we_o;
  logic        next_pc_valid_i;
  logic [63:0] next_pc_i;
  logic [2:0]  state_o;
  logic        halted_o;
  logic [63:0] cycle_cnt_o;
  logic [63:0] instret_o;

  int n_checks = 0;
  int n_fail   = 0;

  stage_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_valid_i    (imem_valid_i),
    .imem_rdata_i    (imem_rdata_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .alu_busy_i      (alu_busy_i),
    .exit_i          (exit_i),
    .rf_wen_i        (rf_wen_i),
    .rf_we_o         (rf_we_o),
    .next_pc_valid_i (next_pc_valid_i),
    .next_pc_i       (next_pc_i),
    .state_o         (state_o),
    .halted_o        (halted_o),
    .cycle_cnt_o     (cycle_cnt_o),
    .instret_o       (instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Stimulus only: runs one instruction starting at a FETCH falling edge.
  // Stops in HALT when ex=1, otherwise returns at the next FETCH.
  task automatic do_instr(input int wait_extra, input int busy, input bit ex,
                          input bit redir, input logic [63:0] tgt,
                          input bit wen, output int cycles);
    cycles = 0;
    rf_wen_i = wen;
    tick(); cycles++;                       // -> WAIT
    repeat (wait_extra) begin tick(); cycles++; end
    imem_valid_i = 1'b1; imem_rdata_i = ADDI_X1;
    tick(); cycles++;                       // -> DECODE
    imem_valid_i = 1'b0;
    tick(); cycles++;                       // -> EXEC
    alu_busy_i = 1'b1;
    repeat (busy) begin tick(); cycles++; end
    alu_busy_i = 1'b0; exit_i = ex;
    tick(); cycles++;                       // -> WB or HALT
    exit_i = 1'b0;
    if (!ex) begin
      next_pc_valid_i = redir; next_pc_i = tgt;
      tick(); cycles++;                     // -> FETCH
      next_pc_valid_i = 1'b0; next_pc_i = 64'd0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL %s state: got %0d expected 0", tag, state_o); end
    n_checks++;
    if (pc_o !== RESET_PC || imem_addr_o !== RESET_PC) begin
      n_fail++; $display("FAIL %s pc: got %h/%h expected %h", tag, pc_o, imem_addr_o, RESET_PC);
    end
    n_checks++;
    if (inst_o !== NOP_INST) begin n_fail++; $display("FAIL %s inst: got %h expected %h", tag, inst_o, NOP_INST); end
    n_checks++;
    if (rf_we_o !== 1'b0 || halted_o !== 1'b0) begin
      n_fail++; $display("FAIL %s we/halt: got %b/%b expected 0/0", tag, rf_we_o, halted_o);
    end
    n_checks++;
    if (cycle_cnt_o !== 64'd0 || instret_o !== 64'd0) begin
      n_fail++; $display("FAIL %s counters: got %0d/%0d expected 0/0", tag, cycle_cnt_o, instret_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;                           // released on a falling edge
    n_checks++;
    if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b expected 1", imem_req_o); end
  endtask

  task automatic test_basic();
    logic [63:0] c0, i0;
    c0 = cycle_cnt_o; i0 = instret_o;
    rf_wen_i = 1'b1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0000) begin
      n_fail++; $display("FAIL basic_fetch: got req=%b addr=%h expected 1/80000000", imem_req_o, imem_addr_o);
    end
    tick();
    n_checks++;
    if (state_o !== 3'd1 || imem_req_o !== 1'b0 || rf_we_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_wait: got st=%0d req=%b we=%b expected 1/0/0", state_o, imem_req_o, rf_we_o);
    end
    imem_valid_i = 1'b1; imem_rdata_i = ADDI_X1;
    tick();
    imem_valid_i = 1'b0;
    n_checks++;
    if (state_o !== 3'd2 || inst_o !== ADDI_X1 || rf_we_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_decode: got st=%0d inst=%h we=%b expected 2/%h/0", state_o, inst_o, rf_we_o, ADDI_X1);
    end
    tick();
    n_checks++;
    if (state_o !== 3'd3 || rf_we_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_exec: got st=%0d we=%b expected 3/0", state_o, rf_we_o);
    end
    tick();
    n_checks++;
    if (state_o !== 3'd4 || rf_we_o !== 1'b1 || pc_o !== 64'h8000_0000) begin
      n_fail++; $display("FAIL basic_wb: got st=%0d we=%b pc=%h expected 4/1/80000000", state_o, rf_we_o, pc_o);
    end
    tick();
    n_checks++;
    if (state_o !== 3'd0 || imem_req_o !== 1'b1 || imem_addr_o !== 64'h8000_0004 || rf_we_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_next: got st=%0d req=%b addr=%h we=%b expected 0/1/80000004/0",
                         state_o, imem_req_o, imem_addr_o, rf_we_o);
    end
`ifdef PERF_CNT_EN
    n_checks++;
    if (cycle_cnt_o !== c0 + 64'd5 || instret_o !== i0 + 64'd1) begin
      n_fail++; $display("FAIL basic_perf: got %0d/%0d expected %0d/%0d", cycle_cnt_o, instret_o, c0 + 64'd5, i0 + 64'd1);
    end
`else
    n_checks++;
    if (cycle_cnt_o !== 64'd0 || instret_o !== 64'd0 || c0 !== 64'd0 || i0 !== 64'd0) begin
      n_fail++; $display("FAIL basic_perf_tied: got %0d/%0d expected 0/0", cycle_cnt_o, instret_o);
    end
`endif
  endtask

  task automatic test_latency();
    int cyc;
    cyc = 0;
    rf_wen_i = 1'b0;
    tick(); cyc++;                          // WAIT
    repeat (3) begin tick(); cyc++; end     // three empty wait cycles
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL lat_wait_hold: got st=%0d expected 1", state_o); end
    imem_valid_i = 1'b1; imem_rdata_i = 32'h0020_0113;
    tick(); cyc++;                          // DECODE
    imem_rdata_i = 32'hDEAD_BEEF;           // spurious response, still valid
    n_checks++;
    if (state_o !== 3'd2 || inst_o !== 32'h0020_0113) begin
      n_fail++; $display("FAIL lat_decode: got st=%0d inst=%h expected 2/00200113", state_o, inst_o);
    end
    tick(); cyc++;                          // EXEC
    imem_valid_i = 1'b0;
    n_checks++;
    if (inst_o !== 32'h0020_0113) begin
      n_fail++; $display("FAIL lat_spurious: got inst=%h expected 00200113", inst_o);
    end
    alu_busy_i = 1'b1;
    repeat (4) begin tick(); cyc++; end
    n_checks++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL lat_busy_hold: got st=%0d expected 3", state_o); end
    alu_busy_i = 1'b0;
    tick(); cyc++;                          // WB
    n_checks++;
    if (state_o !== 3'd4 || rf_we_o !== 1'b0 || pc_o !== 64'h8000_0004 || inst_o !== 32'h0020_0113) begin
      n_fail++; $display("FAIL lat_wb: got st=%0d we=%b pc=%h inst=%h expected 4/0/80000004/00200113",
                         state_o, rf_we_o, pc_o, inst_o);
    end
    tick(); cyc++;                          // FETCH
    n_checks++;
    if (cyc != 12 || state_o !== 3'd0 || imem_addr_o !== 64'h8000_0008) begin
      n_fail++; $display("FAIL lat_total: got cyc=%0d st=%0d addr=%h expected 12/0/80000008", cyc, state_o, imem_addr_o);
    end
  endtask

  task automatic test_redirect();
    int cyc;
    do_instr(0, 0, 1'b0, 1'b1, 64'h8000_0103, 1'b1, cyc);
    n_checks++;
    if (imem_addr_o !== 64'h8000_0100 || cyc != 5) begin
      n_fail++; $display("FAIL redirect: got addr=%h cyc=%0d expected 80000100/5", imem_addr_o, cyc);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    do_instr(1, 0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, cyc);
    n_checks++;
    if (imem_addr_o !== 64'hFFFF_FFFF_FFFF_FFFC || cyc != 6) begin
      n_fail++; $display("FAIL wrap_setup: got addr=%h cyc=%0d expected fffffffffffffffc/6", imem_addr_o, cyc);
    end
    do_instr(0, 2, 1'b0, 1'b0, 64'd0, 1'b0, cyc);
    n_checks++;
    if (imem_addr_o !== 64'd0 || cyc != 7) begin
      n_fail++; $display("FAIL wrap: got addr=%h cyc=%0d expected 0/7", imem_addr_o, cyc);
    end
  endtask

  task automatic test_halt();
    int cyc;
    int bad;
    logic [63:0] c_h;
    do_instr(0, 0, 1'b1, 1'b0, 64'd0, 1'b1, cyc);
    n_checks++;
    if (state_o !== 3'd5 || halted_o !== 1'b1 || pc_o !== 64'd0) begin
      n_fail++; $display("FAIL halt_enter: got st=%0d halted=%b pc=%h expected 5/1/0", state_o, halted_o, pc_o);
    end
    c_h = cycle_cnt_o;
    bad = 0;
    rf_wen_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      imem_valid_i = i[0];
      tick();
      if (state_o !== 3'd5 || imem_req_o !== 1'b0 || rf_we_o !== 1'b0 || halted_o !== 1'b1) bad++;
    end
    imem_valid_i = 1'b0;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL halt_absorb: got %0d bad cycles expected 0", bad); end
    n_checks++;
    if (cycle_cnt_o !== c_h) begin n_fail++; $display("FAIL halt_freeze: got %0d expected %0d", cycle_cnt_o, c_h); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    // Reset while HALTed, then restart.
    #2 rst_n = 1'b0; #1;
    check_reset_outputs("rst_halt");
    tick(); rst_n = 1'b1;
    tick();                                 // WAIT
    n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL rst_to_wait: got st=%0d expected 1", state_o); end
    // Reset mid-fetch while the response is in flight.
    #2 rst_n = 1'b0; #1;
    check_reset_outputs("rst_wait");
    imem_valid_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    tick(); rst_n = 1'b1;
    n_checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
      n_fail++; $display("FAIL rst_refetch: got req=%b addr=%h expected 1/%h", imem_req_o, imem_addr_o, RESET_PC);
    end
    tick();                                 // late response arrives in FETCH
    imem_valid_i = 1'b0;
    n_checks++;
    if (state_o !== 3'd1 || inst_o !== NOP_INST) begin
      n_fail++; $display("FAIL rst_discard: got st=%0d inst=%h expected 1/%h", state_o, inst_o, NOP_INST);
    end
    // Reach EXEC with a busy ALU and reset there.
    imem_valid_i = 1'b1; imem_rdata_i = ADDI_X1;
    tick(); imem_valid_i = 1'b0;
    alu_busy_i = 1'b1;
    tick(); tick();
    n_checks++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL rst_pre_exec: got st=%0d expected 3", state_o); end
    #2 rst_n = 1'b0; #1;
    check_reset_outputs("rst_exec");
    alu_busy_i = 1'b0;
    tick(); rst_n = 1'b1;
    do_instr(0, 0, 1'b0, 1'b0, 64'd0, 1'b1, cyc);
    n_checks++;
    if (imem_addr_o !== RESET_PC + 64'd4 || cyc != 5) begin
      n_fail++; $display("FAIL rst_resume: got addr=%h cyc=%0d expected %h/5", imem_addr_o, cyc, RESET_PC + 64'd4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_valid_i = 1'b0; imem_rdata_i = 32'd0;
    alu_busy_i = 1'b0; exit_i = 1'b0; rf_wen_i = 1'b0;
    next_pc_valid_i = 1'b0; next_pc_i = 64'd0;

    test_reset();
    test_basic();
    test_latency();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_ctrl.md
STAGE_CTRL -- requirements
Module: stage_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req_o  output  1  instruction fetch request strobe.
REQ-005 SHALL have port imem_addr_o  output  64  fetch address, equal to the current PC.
REQ-006 SHALL have port imem_valid_i  input  1  fetch response valid.
REQ-007 SHALL have port imem_rdata_i  input  32  fetch response instruction word.
REQ-008 SHALL have port inst_o  output  32  latched instruction word to the decoder.
REQ-009 SHALL have port pc_o  output  64  current PC to the decoder.
REQ-010 SHALL have port alu_busy_i  input  1  multi-cycle MUL/DIV operation in progress.
REQ-011 SHALL have port exit_i  input  1  decoder EBREAK indication.
REQ-012 SHALL have port rf_wen_i  input  1  decoder register-write request.
REQ-013 SHALL have port rf_we_o  output  1  gated register-file write strobe.
REQ-014 SHALL have port next_pc_valid_i  input  1  redirect present; otherwise next PC is PC+4.
REQ-015 SHALL have port next_pc_i  input  64  redirect target.
REQ-016 SHALL have port state_o  output  3  current state encoding.
REQ-017 SHALL have port halted_o  output  1  high in HALT.
REQ-018 SHALL have ports cycle_cnt_o and instret_o  output  64 each  performance counters.

Function
REQ-019 SHALL encode the states FETCH=0, WAIT=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH.
REQ-020 FETCH SHALL drive imem_req_o=1 for exactly one cycle with imem_addr_o=PC, then go to WAIT.
REQ-021 WAIT SHALL hold imem_req_o=0 and, when imem_valid_i=1, latch imem_rdata_i into inst_o and go to DECODE; it SHALL stay in WAIT otherwise.
REQ-022 imem_valid_i SHALL be ignored in every state other than WAIT.
REQ-023 DECODE SHALL last exactly one cycle, then go to EXEC.
REQ-024 EXEC SHALL stay in EXEC while alu_busy_i=1; when alu_busy_i=0 it SHALL go to HALT if exit_i=1, else to WB.
REQ-025 WB SHALL drive rf_we_o=rf_wen_i for that cycle only; rf_we_o SHALL be 0 in all other states.
REQ-026 WB SHALL load PC with {next_pc_i[63:2],2'b00} if next_pc_valid_i=1, else PC+4 modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0), then go to FETCH.
REQ-027 HALT SHALL be absorbing until reset, with halted_o=1, no requests and no writes; PC SHALL keep the EBREAK address.
REQ-028 With a memory that answers in the cycle after the request, latency SHALL be 5 cycles per instruction, plus one cycle for each extra wait cycle and each busy cycle.
REQ-029 inst_o and pc_o SHALL stay stable from DECODE through WB.

Reset
REQ-030 On rst_n=0, at any time including mid-fetch or mid-EXEC, the block SHALL immediately set state=FETCH, PC=RESET_PC, inst_o=32'h0000_0013 (NOP), counters=0, rf_we_o=0 and halted_o=0.
REQ-031 A fetch response that was outstanding at reset SHALL be discarded (covered by REQ-022).

Configuration
REQ-032 With PERF_CNT_EN defined, cycle_cnt_o SHALL increment every cycle outside HALT and instret_o SHALL increment on each WB cycle; both SHALL wrap modulo 2^64.
REQ-033 Without PERF_CNT_EN, the counter registers SHALL be absent and both ports SHALL be tied to 0.

Verification
REQ-034 After reset release, with 1-cycle memory returning addi (32'h0010_0093) and rf_wen_i=1: imem_req_o=1 at 0x8000_0000, rf_we_o pulses in cycle 5, next request at 0x8000_0004.
REQ-035 imem_valid_i delayed 3 cycles, then alu_busy_i held 4 cycles: instruction takes 12 cycles; a spurious valid in DECODE does not change inst_o.
REQ-036 In WB, next_pc_valid_i=1 with next_pc_i=64'h8000_0103: next fetch address is 0x8000_0100.
REQ-037 PC=64'hFFFF_FFFF_FFFF_FFFC with no redirect: next fetch address is 0.
REQ-038 exit_i=1 in EXEC: state_o=5, halted_o=1, no further imem_req_o, rf_we_o stays 0; with PERF_CNT_EN, cycle_cnt_o freezes.
REQ-039 rst_n pulsed low during WAIT and during EXEC: outputs reset immediately per REQ-030, and the fetch restarts at RESET_PC.
